shift_arbiter: RTL

Shares one `r_shifter` instance (32-bit right shifter, logical or arithmetic) between two requesters. Each requester gets a valid/ready request channel, and the block issues one registered response carrying the requester ID. The block sits between the ALU shift path (requester 0) and the multi-cycle unit (requester 1), which both need right shifts but never justify a second barrel shifter. Arbitration is round-robin or fixed priority, selected at compile time. Per-requester saturating grant counters are provided for performance debug.

---
 rtl/shift_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two valid/ready requesters share one 32-bit right shifter behind a one-entry response stage.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; by default requester 0 has fixed priority.

module r_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic             arith,
  output logic [WIDTH-1:0] y
);
  assign y = arith ? $unsigned($signed(a) >>> b) : (a >> b);
endmodule

module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [SHW-1:0]   req0_b,
  input  logic             req0_arith,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [SHW-1:0]   req1_b,
  input  logic             req1_arith,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic [CNTW-1:0]  grant_cnt0,
  output logic [CNTW-1:0]  grant_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nx;
  logic             can_accept, grant0, grant1, acc0, acc1;
  logic             ptr;
  logic [WIDTH-1:0] op_a;
  logic [SHW-1:0]   op_b;
  logic             op_arith;
  logic             id_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    can_accept = (state == EMPTY) || rsp_ready;
    grant0     = req0_valid && (!req1_valid || !ptr);
    grant1     = req1_valid && (!req0_valid ||  ptr);
    req0_ready = can_accept && grant0 && !rst;
    req1_ready = can_accept && grant1 && !rst;
    acc0       = req0_ready;
    acc1       = req1_ready;
    if (acc0 || acc1)
      state_nx = FULL;
    else if (state == FULL && rsp_ready)
      state_nx = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  // Operand register is reset so the shifter output reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_arith <= 1'b0;
      id_q     <= 1'b0;
    end else if (acc0) begin
      op_a     <= req0_a;
      op_b     <= req0_b;
      op_arith <= req0_arith;
      id_q     <= 1'b0;
    end else if (acc1) begin
      op_a     <= req1_a;
      op_b     <= req1_b;
      op_arith <= req1_arith;
      id_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (acc0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNTW'(1);
      if (acc1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNTW'(1);
    end
  end

`ifdef SHIFT_ARB_RR_EN
  // Pointer favours whichever requester was not served last.
  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (acc0) ptr <= 1'b1;
    else if (acc1) ptr <= 1'b0;
  end
`else
  assign ptr = 1'b0;
`endif

  r_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .a     (op_a),
    .b     (op_b),
    .arith (op_arith),
    .y     (rsp_data)
  );

  assign rsp_valid = (state == FULL);
  assign rsp_id    = id_q;

endmodule
